// File: rtl/parity_engine.sv
// Parity generator plus a serial receive-frame parity checker with a sticky
// error flag and a saturating mismatch counter.
module parity_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  par_en,
    input  logic [1:0]            PAR_TYP,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    output logic                  PAR_bit,
    output logic                  par_valid,
    input  logic                  frame_start,
    input  logic                  rx_bit,
    input  logic                  bit_valid,
    input  logic                  err_clr,
    output logic                  chk_done,
    output logic                  par_err,
    output logic                  par_err_sticky,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, ACCUM, WAIT_PAR} state_t;

    // Parity of a data set given its XOR-reduction and the parity mode.
    function automatic logic f_parity(input logic xr, input logic [1:0] typ);
        case (typ)
            2'b00:   return xr;
            2'b01:   return ~xr;
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_par_bit;
    logic                 r_par_valid;
    logic                 r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic [1:0]           r_mode;
    logic                 r_chk_done;
    logic                 r_par_err;
    logic                 r_sticky;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 w_restart;
    logic                 w_accum_bit;
    logic                 w_check;
    logic                 w_mismatch;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_bit   <= 1'b0;
            r_par_valid <= 1'b0;
        end else begin
            r_par_valid <= 1'b0;
            if (par_en && Data_Valid) begin
                r_par_bit   <= f_parity(^P_DATA, PAR_TYP);
                r_par_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_restart    = par_en && frame_start;
        w_accum_bit  = 1'b0;
        w_check      = 1'b0;
        w_mismatch   = 1'b0;
        if (!par_en) begin
            w_next_state = IDLE;
        end else if (frame_start) begin
            w_next_state = ACCUM;
        end else begin
            case (r_state)
                ACCUM: begin
                    w_accum_bit = bit_valid;
                    if (bit_valid && r_cnt == LAST_BIT) w_next_state = WAIT_PAR;
                end
                WAIT_PAR: begin
                    w_check    = bit_valid;
                    w_mismatch = bit_valid && (rx_bit != f_parity(r_acc, r_mode));
                    if (bit_valid) w_next_state = IDLE;
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= 1'b0;
            r_cnt      <= '0;
            r_mode     <= 2'b00;
            r_chk_done <= 1'b0;
            r_par_err  <= 1'b0;
            r_sticky   <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_chk_done <= w_check;
            r_par_err  <= w_mismatch;
            if (w_restart) begin
                r_acc  <= 1'b0;
                r_cnt  <= '0;
                r_mode <= PAR_TYP;
            end else if (w_accum_bit) begin
                r_acc <= r_acc ^ rx_bit;
                r_cnt <= r_cnt + 1'b1;
            end
            // A clear coinciding with a mismatch wins; the par_err strobe still fires.
            if (err_clr) begin
                r_sticky  <= 1'b0;
                r_err_cnt <= '0;
            end else if (w_mismatch) begin
                r_sticky <= 1'b1;
                if (r_err_cnt != ERR_MAX) r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign PAR_bit        = r_par_bit;
    assign par_valid      = r_par_valid;
    assign chk_done       = r_chk_done;
    assign par_err        = r_par_err;
    assign par_err_sticky = r_sticky;
    assign err_cnt        = r_err_cnt;

endmodule

// File: tb/tb_parity_engine.sv
// Self-checking bench for parity_engine: directed scenarios plus random traffic
// compared every cycle against a frame-level reference model.
module tb_parity_engine;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst, par_en, data_valid, frame_start, rx_bit, bit_valid, err_clr;
    logic [1:0]    par_typ;
    logic [DW-1:0] p_data;

    logic          par_bit, par_valid, chk_done, par_err, sticky;
    logic [7:0]    err_cnt;
    logic          par_bit_s, par_valid_s, chk_done_s, par_err_s, sticky_s;
    logic [1:0]    err_cnt_s;

    int n_checks = 0;
    int n_errors = 0;
    int seen_done, seen_err;

    // Reference model state.
    logic          m_par_bit, m_par_valid, m_chk_done, m_par_err, m_sticky;
    int            m_cnt, m_cnt_s;
    bit            m_active;
    int            m_nbits;
    logic [31:0]   m_data;
    logic [1:0]    m_mode;

    int   sat_exp[5] = '{1, 2, 3, 3, 3};
    logic gen_exp[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [DW-1:0] frame_data;

    parity_engine #(.DATA_WIDTH(DW), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .par_en(par_en), .PAR_TYP(par_typ), .P_DATA(p_data),
        .Data_Valid(data_valid), .PAR_bit(par_bit), .par_valid(par_valid),
        .frame_start(frame_start), .rx_bit(rx_bit), .bit_valid(bit_valid), .err_clr(err_clr),
        .chk_done(chk_done), .par_err(par_err), .par_err_sticky(sticky), .err_cnt(err_cnt)
    );

    parity_engine #(.DATA_WIDTH(DW), .ERR_CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .par_en(par_en), .PAR_TYP(par_typ), .P_DATA(p_data),
        .Data_Valid(data_valid), .PAR_bit(par_bit_s), .par_valid(par_valid_s),
        .frame_start(frame_start), .rx_bit(rx_bit), .bit_valid(bit_valid), .err_clr(err_clr),
        .chk_done(chk_done_s), .par_err(par_err_s), .par_err_sticky(sticky_s), .err_cnt(err_cnt_s)
    );

    always #5 clk = ~clk;

    function automatic logic ref_par(input int ones, input logic [1:0] typ);
        case (typ)
            2'b00:   return logic'(ones % 2);
            2'b01:   return logic'(1 - ones % 2);
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_update();
        if (rst) begin
            m_par_bit = 0; m_par_valid = 0; m_chk_done = 0; m_par_err = 0;
            m_sticky = 0; m_cnt = 0; m_cnt_s = 0; m_active = 0;
            return;
        end
        m_par_valid = 0;
        if (par_en && data_valid) begin
            m_par_bit   = ref_par($countones(p_data), par_typ);
            m_par_valid = 1;
        end
        m_chk_done = 0;
        m_par_err  = 0;
        if (!par_en) begin
            m_active = 0;
        end else if (frame_start) begin
            m_active = 1; m_nbits = 0; m_data = '0; m_mode = par_typ;
        end else if (m_active && bit_valid) begin
            if (m_nbits < DW) begin
                m_data[m_nbits] = rx_bit;
                m_nbits++;
            end else begin
                m_chk_done = 1;
                m_par_err  = (rx_bit != ref_par($countones(m_data), m_mode));
                m_active   = 0;
            end
        end
        if (err_clr) begin
            m_sticky = 0; m_cnt = 0; m_cnt_s = 0;
        end else if (m_par_err) begin
            m_sticky = 1;
            m_cnt    = (m_cnt   < 255) ? m_cnt + 1   : 255;
            m_cnt_s  = (m_cnt_s < 3)   ? m_cnt_s + 1 : 3;
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        seen_done += int'(chk_done);
        seen_err  += int'(par_err);
        check("par_bit",   par_bit,   m_par_bit);
        check("par_valid", par_valid, m_par_valid);
        check("chk_done",  chk_done,  m_chk_done);
        check("par_err",   par_err,   m_par_err);
        check("sticky",    sticky,    m_sticky);
        check("err_cnt",   err_cnt,   m_cnt);
        check("err_cnt_s", err_cnt_s, m_cnt_s);
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        rx_bit    = b;
        step();
        bit_valid = 1'b0;
    endtask

    // Frame start followed by the first nbits data bits, LSB first.
    task automatic send_frame(input logic [DW-1:0] data, input int nbits, input logic [1:0] mode);
        frame_start = 1'b1;
        par_typ     = mode;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < nbits; i++) send_bit(data[i]);
    endtask

    initial begin
        rst = 1; par_en = 0; par_typ = 0; p_data = 0; data_valid = 0;
        frame_start = 0; rx_bit = 0; bit_valid = 0; err_clr = 0;
        seen_done = 0; seen_err = 0; m_nbits = 0; m_data = '0; m_mode = 0;
        step();
        step();
        check("reset_par_bit", par_bit, 1'b0);
        check("reset_err_cnt", err_cnt, 8'd0);
        rst = 0; par_en = 1;

        // Generator: 0xA5 in all four modes.
        for (int t = 0; t < 4; t++) begin
            par_typ = 2'(t); p_data = 8'hA5; data_valid = 1;
            step();
            check("gen_valid", par_valid, 1'b1);
            check("gen_bit", par_bit, gen_exp[t]);
            data_valid = 0;
            step();
            check("gen_valid_low", par_valid, 1'b0);
            check("gen_hold", par_bit, gen_exp[t]);
        end
        // Back-to-back generation.
        data_valid = 1;
        for (int i = 0; i < 4; i++) begin
            p_data = 8'($urandom); par_typ = 2'(i % 2);
            step();
        end
        // par_en low holds the generator (last bit forced to mark first).
        par_typ = 2'b10; step();
        par_en = 0; par_typ = 2'b11; step();
        check("gen_disabled_hold", par_bit, 1'b1);
        check("gen_disabled_valid", par_valid, 1'b0);
        data_valid = 0; par_en = 1; step();

        // Passing frame.
        send_frame(8'h0F, DW, 2'b00);
        send_bit(1'b0);
        check("pass_done", chk_done, 1'b1);
        check("pass_err", par_err, 1'b0);
        check("pass_cnt", err_cnt, 8'd0);
        step();
        check("pass_done_1cyc", chk_done, 1'b0);

        // Failing frame then clear.
        send_frame(8'h0F, DW, 2'b00);
        send_bit(1'b1);
        check("fail_done", chk_done, 1'b1);
        check("fail_err", par_err, 1'b1);
        check("fail_cnt", err_cnt, 8'd1);
        check("fail_sticky", sticky, 1'b1);
        err_clr = 1; step(); err_clr = 0;
        check("clr_cnt", err_cnt, 8'd0);
        check("clr_sticky", sticky, 1'b0);

        // Saturation.
        for (int i = 0; i < 5; i++) begin
            send_frame(8'h0F, DW, 2'b00);
            send_bit(1'b1);
            check("sat_cnt_s", err_cnt_s, 32'(sat_exp[i]));
            check("sat_cnt", err_cnt, 32'(i + 1));
        end

        // Clear coinciding with a mismatch.
        send_frame(8'h0F, DW, 2'b00);
        err_clr = 1;
        send_bit(1'b1);
        err_clr = 0;
        check("clr_win_err", par_err, 1'b1);
        check("clr_win_cnt", err_cnt, 8'd0);
        check("clr_win_sticky", sticky, 1'b0);

        // Mid-frame PAR_TYP change: frame latched as odd, 0x0F needs parity 1.
        frame_start = 1; par_typ = 2'b01; step(); frame_start = 0;
        par_typ = 2'b00;
        for (int i = 0; i < DW; i++) send_bit(i < 4);
        send_bit(1'b1);
        check("mode_latched_done", chk_done, 1'b1);
        check("mode_latched_err", par_err, 1'b0);

        // Aborted frame then a full good frame.
        seen_done = 0; seen_err = 0;
        send_frame(8'h0F, 3, 2'b00);
        send_frame(8'h0F, DW, 2'b00);
        send_bit(1'b0);
        step();
        check("abort_done_count", seen_done, 1);
        check("abort_err_count", seen_err, 0);

        // Bits in IDLE are ignored.
        seen_done = 0;
        for (int i = 0; i < DW + 2; i++) send_bit(1'b1);
        check("idle_ignore", seen_done, 0);

        // Reset mid-frame.
        seen_done = 0;
        frame_data = 8'h0F;
        send_frame(frame_data, 4, 2'b00);
        rst = 1; step(); rst = 0;
        for (int i = 4; i < DW; i++) send_bit(frame_data[i]);
        send_bit(1'b0);
        check("rst_frame_done", seen_done, 0);
        check("rst_par_bit", par_bit, 1'b0);
        check("rst_par_valid", par_valid, 1'b0);
        check("rst_err", par_err, 1'b0);
        check("rst_sticky", sticky, 1'b0);
        check("rst_cnt", err_cnt, 8'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(199) == 0);
            par_en      = ($urandom_range(19) != 0);
            par_typ     = 2'($urandom);
            p_data      = 8'($urandom);
            data_valid  = ($urandom_range(2) == 0);
            frame_start = ($urandom_range(14) == 0);
            bit_valid   = ($urandom_range(9) < 7);
            rx_bit      = 1'($urandom);
            err_clr     = ($urandom_range(39) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/parity_engine.md
PARITY_ENGINE -- requirements
Module: parity_engine

Interface
REQ-001 Parameter DATA_WIDTH, default 8, sets the number of data bits per frame (legal range 1..32).
REQ-002 Parameter ERR_CNT_W, default 8, sets the width of the saturating parity-error counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 par_en  input  1  global enable for generator and checker.
REQ-006 PAR_TYP  input  2  parity mode: 00 even, 01 odd, 10 mark (always 1), 11 space (always 0).
REQ-007 P_DATA  input  DATA_WIDTH  parallel data for parity generation.
REQ-008 Data_Valid  input  1  P_DATA qualifier for the generator.
REQ-009 PAR_bit  output  1  registered generated parity bit.
REQ-010 par_valid  output  1  one-cycle strobe marking a new PAR_bit.
REQ-011 frame_start  input  1  starts (or restarts) a receive-check frame.
REQ-012 rx_bit  input  1  serial received bit (data bits LSB first, then parity bit).
REQ-013 bit_valid  input  1  rx_bit qualifier.
REQ-014 err_clr  input  1  clears par_err_sticky and err_cnt.
REQ-015 chk_done  output  1  one-cycle strobe at end of each checked frame.
REQ-016 par_err  output  1  one-cycle strobe, coincident with chk_done, on parity mismatch.
REQ-017 par_err_sticky  output  1  set on any mismatch; held until err_clr or rst.
REQ-018 err_cnt  output  ERR_CNT_W  saturating mismatch count.

Function
REQ-019 Generator: when Data_Valid and par_en are both 1, PAR_bit SHALL update on that edge to f(P_DATA, PAR_TYP) and par_valid SHALL be 1 for exactly the following cycle; latency is 1 cycle.
REQ-020 f: even = XOR-reduction of P_DATA; odd = its inverse; mark = 1; space = 0.
REQ-021 Without a qualifying Data_Valid, PAR_bit SHALL hold its value and par_valid SHALL be 0.
REQ-022 Back-to-back Data_Valid SHALL produce a new PAR_bit and a par_valid strobe on every cycle.
REQ-023 The checker FSM SHALL have states IDLE, ACCUM and WAIT_PAR.
REQ-024 On frame_start with par_en=1, the checker SHALL enter ACCUM from any state, clear the accumulator and bit counter, and latch PAR_TYP as the frame mode.
REQ-025 In ACCUM, each bit_valid SHALL XOR rx_bit into the accumulator and increment the counter; on the DATA_WIDTH-th bit the FSM SHALL move to WAIT_PAR.
REQ-026 In WAIT_PAR, bit_valid SHALL compare rx_bit with the expected parity (f applied to the accumulator using the latched mode), pulse chk_done next cycle, pulse par_err with it on mismatch, and return to IDLE.
REQ-027 If frame_start and bit_valid coincide, frame_start SHALL win: restart with count 0 and that rx_bit discarded.
REQ-028 An aborted frame (restart before its parity bit arrives) SHALL produce no chk_done and no par_err.
REQ-029 bit_valid in IDLE SHALL be ignored.
REQ-030 On mismatch, err_cnt SHALL increment by 1 and saturate at 2^ERR_CNT_W-1, and par_err_sticky SHALL be set.
REQ-031 err_clr SHALL zero err_cnt and par_err_sticky next cycle; if it coincides with a mismatch, the clear SHALL win and par_err SHALL still pulse.
REQ-032 With par_en=0, the generator SHALL hold, the checker SHALL go to IDLE, and strobes SHALL be 0; err_cnt and par_err_sticky SHALL hold.
REQ-033 Mid-frame changes to PAR_TYP SHALL NOT affect the frame in progress.

Reset
REQ-034 With rst=1 at a clock edge, PAR_bit, par_valid, chk_done, par_err, par_err_sticky and err_cnt SHALL be 0, the FSM SHALL be IDLE, and the accumulator and counter SHALL be 0.
REQ-035 rst SHALL take priority over all other inputs; a frame in progress SHALL be discarded without strobes.

Verification
REQ-036 Generator: P_DATA=0xA5 with PAR_TYP=00/01/10/11 in turn -> PAR_bit 0/1/1/0, each with a 1-cycle par_valid one cycle after Data_Valid.
REQ-037 Check pass: frame_start, bits of 0x0F LSB first, parity bit 0, mode even -> chk_done pulse, par_err=0, err_cnt=0.
REQ-038 Check fail: same frame with parity bit 1 -> chk_done and par_err pulse together, err_cnt=1, par_err_sticky=1; then err_clr -> both 0.
REQ-039 Saturation: ERR_CNT_W=2, five failing frames -> err_cnt 1,2,3,3,3.
REQ-040 Abort: frame_start, 3 data bits, frame_start, full good frame -> exactly one chk_done, no par_err.
REQ-041 Reset mid-frame: rst after 4 data bits, then the remaining bits -> no chk_done, FSM IDLE, all outputs 0.
